// File: rtl/elevator_pkg.sv
// Shared types for the SCAN elevator controller: FSM state codes and
// motor direction encodings.
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UP    = 3'd1,
    ST_DOWN  = 3'd2,
    ST_DOOR  = 3'd3,
    ST_EMERG = 3'd4
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_call_reg.sv
// Pending-call register for the elevator: latches call pulses, clears the
// served floor, and reduces the calls to above/below/here relative to the cab.
module elevator_call_reg
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = 8,
  parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]  current_floor,
  input  logic                clear_here,
  input  logic                flush,
  output logic [N_FLOORS-1:0] pending,
  output logic                above,
  output logic                below,
  output logic                here
);

  logic [N_FLOORS-1:0] pending_q;
  logic [N_FLOORS-1:0] pending_d;
  logic [N_FLOORS-1:0] clear_mask;

  // An out-of-range floor matches no bit, so nothing is cleared or reported as here.
  always_comb begin
    clear_mask = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (clear_here && (current_floor == FLOOR_W'(i))) clear_mask[i] = 1'b1;
    end
    pending_d = flush ? '0 : ((pending_q | call_req) & ~clear_mask);
  end

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i] && (FLOOR_W'(i) > current_floor)) above = 1'b1;
      if (pending_q[i] && (FLOOR_W'(i) < current_floor)) below = 1'b1;
      if ((pending_q[i] || call_req[i]) && (FLOOR_W'(i) == current_floor)) here = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor SCAN elevator controller: serves latched calls in collective order,
// holds the door open for a timed stop, and returns to ground on emergency.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = 8,
  parameter int FLOOR_W     = $clog2(N_FLOORS),
  parameter int DOOR_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                emergency,
  input  logic [FLOOR_W-1:0]  current_floor,
  input  logic [N_FLOORS-1:0] call_req,
  output logic                motor_on,
  output logic                motor_dir,
  output logic                door_open,
  output logic [2:0]          state_led,
  output logic [N_FLOORS-1:0] pending
);

  localparam int TIMER_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DOOR_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               last_dir_q, last_dir_d;
  logic               above, below, here;
  logic               floor_valid, at_ground, clear_here, flush;

  assign floor_valid = ({1'b0, current_floor} < (FLOOR_W + 1)'(N_FLOORS));
  assign at_ground   = (current_floor == '0);
  assign clear_here  = (state_d == ST_DOOR);
  assign flush       = (state_d == ST_EMERG) || (state_q == ST_EMERG);

  elevator_call_reg #(
    .N_FLOORS(N_FLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_call_reg (
    .clock        (clock),
    .reset        (reset),
    .call_req     (call_req),
    .current_floor(current_floor),
    .clear_here   (clear_here),
    .flush        (flush),
    .pending      (pending),
    .above        (above),
    .below        (below),
    .here         (here)
  );

  // A bad floor reading freezes the FSM; emergency and its release still act.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    last_dir_d = last_dir_q;
    if (emergency) begin
      state_d = ST_EMERG;
    end else if (state_q == ST_EMERG) begin
      state_d = ST_IDLE;
    end else if (floor_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (here) begin
            state_d = ST_DOOR;
            timer_d = TIMER_LOAD;
          end else if (above) begin
            state_d    = ST_UP;
            last_dir_d = DIR_UP;
          end else if (below) begin
            state_d    = ST_DOWN;
            last_dir_d = DIR_DOWN;
          end
        end
        ST_UP: begin
          if (here) begin
            state_d = ST_DOOR;
            timer_d = TIMER_LOAD;
          end else if (!above) begin
            if (below) begin
              state_d    = ST_DOWN;
              last_dir_d = DIR_DOWN;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DOWN: begin
          if (here) begin
            state_d = ST_DOOR;
            timer_d = TIMER_LOAD;
          end else if (!below) begin
            if (above) begin
              state_d    = ST_UP;
              last_dir_d = DIR_UP;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DOOR: begin
          if (here) begin
            timer_d = TIMER_LOAD;
          end else if (timer_q != '0) begin
            timer_d = timer_q - TIMER_W'(1);
          end else if (last_dir_q == DIR_UP) begin
            if (above) state_d = ST_UP;
            else if (below) begin
              state_d    = ST_DOWN;
              last_dir_d = DIR_DOWN;
            end else state_d = ST_IDLE;
          end else begin
            if (below) state_d = ST_DOWN;
            else if (above) begin
              state_d    = ST_UP;
              last_dir_d = DIR_UP;
            end else state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      last_dir_q <= DIR_DOWN;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      last_dir_q <= last_dir_d;
    end
  end

  always_comb begin
    motor_on  = 1'b0;
    motor_dir = DIR_DOWN;
    door_open = 1'b0;
    case (state_q)
      ST_UP: begin
        motor_on  = floor_valid;
        motor_dir = DIR_UP;
      end
      ST_DOWN: motor_on = floor_valid;
      ST_DOOR: door_open = 1'b1;
      ST_EMERG: begin
        if (at_ground) door_open = 1'b1;
        else           motor_on  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_led = state_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl (8 floors, 4-bit floor bus so an
// invalid floor can be driven): directed vectors with hand-computed results.
module tb_elevator_scan_ctrl;

  logic       clock;
  logic       reset;
  logic       emergency;
  logic [3:0] current_floor;
  logic [7:0] call_req;
  logic       motor_on;
  logic       motor_dir;
  logic       door_open;
  logic [2:0] state_led;
  logic [7:0] pending;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       mo;
    logic       md;
    logic       dop;
    logic [7:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  elevator_scan_ctrl #(
    .N_FLOORS   (8),
    .FLOOR_W    (4),
    .DOOR_CYCLES(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .emergency    (emergency),
    .current_floor(current_floor),
    .call_req     (call_req),
    .motor_on     (motor_on),
    .motor_dir    (motor_dir),
    .door_open    (door_open),
    .state_led    (state_led),
    .pending      (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input exp_t e);
    vectors++;
    if ({state_led, motor_on, motor_dir, door_open, pending} !==
        {e.st, e.mo, e.md, e.dop, e.pend}) begin
      miscompares++;
      $display("[TB] FAIL %s: got st=%0d mo=%b md=%b door=%b pend=%h, want st=%0d mo=%b md=%b door=%b pend=%h",
               e.tag, state_led, motor_on, motor_dir, door_open, pending,
               e.st, e.mo, e.md, e.dop, e.pend);
    end
  endtask

  // Inputs change on the falling edge; the expected result after the next rising edge is queued.
  task automatic applyStimulus(input string tag, input logic [3:0] f, input logic [7:0] c,
                               input logic em, input logic [2:0] st, input logic mo,
                               input logic md, input logic dop, input logic [7:0] pend);
    exp_t e;
    @(negedge clock);
    current_floor = f;
    call_req      = c;
    emergency     = em;
    e.tag = tag; e.st = st; e.mo = mo; e.md = md; e.dop = dop; e.pend = pend;
    exp_q.push_back(e);
  endtask

  always @(posedge clock) begin
    #2;
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d queued, want 0", exp_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t r;
    r.st = 3'd0; r.mo = 1'b0; r.md = 1'b0; r.dop = 1'b0; r.pend = 8'h00;
    reset = 1'b1; emergency = 1'b0; current_floor = 4'd0; call_req = 8'h00;
    repeat (2) @(negedge clock);
    #1;
    r.tag = "reset_state";
    checkOutput(r);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus("init", 4'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);

    // single call to floor 5 from ground
    applyStimulus("s1_latch", 4'd0, 8'h20, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h20);
    applyStimulus("s1_up0",   4'd0, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h20);
    for (int f = 1; f <= 4; f++)
      applyStimulus("s1_up",  4'(f), 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h20);
    applyStimulus("s1_arrive", 4'd5, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3)
      applyStimulus("s1_door", 4'd5, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus("s1_idle",  4'd5, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);

    // calls at 6 and 2 issued while passing floor 3 on the way up
    applyStimulus("s2_home",  4'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus("s2_latch", 4'd0, 8'h40, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h40);
    applyStimulus("s2_up0",   4'd0, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h40);
    applyStimulus("s2_up1",   4'd1, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h40);
    applyStimulus("s2_up2",   4'd2, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h40);
    applyStimulus("s2_calls", 4'd3, 8'h44, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h44);
    applyStimulus("s2_up4",   4'd4, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h44);
    applyStimulus("s2_up5",   4'd5, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h44);
    applyStimulus("s2_stop6", 4'd6, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h04);
    repeat (3)
      applyStimulus("s2_door6", 4'd6, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h04);
    applyStimulus("s2_rev",   4'd6, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h04);
    for (int f = 5; f >= 3; f--)
      applyStimulus("s2_down", 4'(f), 8'h00, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h04);
    applyStimulus("s2_stop2", 4'd2, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3)
      applyStimulus("s2_door2", 4'd2, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus("s2_idle",  4'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);

    // call to the current floor, re-pressed during the second door cycle
    applyStimulus("s3_at4",   4'd4, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus("s3_door1", 4'd4, 8'h10, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus("s3_door2", 4'd4, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus("s3_repress", 4'd4, 8'h10, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3)
      applyStimulus("s3_door", 4'd4, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus("s3_idle",  4'd4, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);

    // emergency while travelling up through floor 3 with calls at 5 and 6
    applyStimulus("s4_home",  4'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus("s4_latch", 4'd0, 8'h60, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h60);
    for (int f = 0; f <= 3; f++)
      applyStimulus("s4_up",  4'(f), 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h60);
    applyStimulus("s4_emerg", 4'd3, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus("s4_ignore", 4'd3, 8'h08, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus("s4_dn2",   4'd2, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus("s4_dn1",   4'd1, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus("s4_ground", 4'd0, 8'h00, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus("s4_release", 4'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);

    // asynchronous reset while the door is open with calls pending
    applyStimulus("s5_door",  4'd0, 8'h0D, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h0C);
    applyStimulus("s5_hold",  4'd0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h0C);
    @(negedge clock);
    call_req = 8'h00;
    #1 reset = 1'b1;
    #1;
    r.tag = "s5_async_reset";
    checkOutput(r);
    @(negedge clock);
    reset = 1'b0;

    // top floor with a call below, then an out-of-range floor reading
    applyStimulus("s6_top",   4'd7, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus("s6_latch", 4'd7, 8'h02, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h02);
    applyStimulus("s6_down",  4'd7, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h02);
    applyStimulus("s6_bad",   4'd9, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'h02);
    applyStimulus("s6_badcall", 4'd9, 8'h80, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'h82);
    applyStimulus("s6_recover", 4'd6, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h82);

    repeat (3) @(posedge clock);
    #3;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
